// File: rtl/uart_tx_if.sv
// Byte-send handshake and serial line of the UART transmitter.
// The master side requests frames; the slave side (uart_tx) drives the line and status.
interface uart_tx_if;
  logic [7:0] in_data;
  logic       in_send_en;
  logic       out_tx;
  logic       out_bs;
  logic       out_rd;

  modport master (
    output in_data,
    output in_send_en,
    input  out_tx,
    input  out_bs,
    input  out_rd
  );

  modport slave (
    input  in_data,
    input  in_send_en,
    output out_tx,
    output out_bs,
    output out_rd
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: LSB-first 8N1/8N2 framing with registered line and status outputs.
// Optional even-parity bit between data and stop bits is enabled by defining UART_TX_PARITY_EN.
module uart_tx #(
  parameter int CLK_FREQ_HZ = 27000000,
  parameter int BAUD_RATE   = 115200,
  parameter int STOP_BITS   = 1
) (
  input  logic     in_clk,
  input  logic     in_rst,
  uart_tx_if.slave bus
);

  localparam int CPB   = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CNT_W = (CPB > 2) ? $clog2(CPB) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CPB - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  if (CPB < 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_check
    $error("uart_tx: CLK_FREQ_HZ/BAUD_RATE must be >= 2 and STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
`ifdef UART_TX_PARITY_EN
  logic             parity_bit;
`endif

  logic bit_end;
  assign bit_end = (baud_cnt == CNT_LAST);

  // NOTE: every register here uses <= so all updates in a cycle see the pre-edge values.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit  <= 1'b0;
`endif
      bus.out_tx  <= 1'b1;
      bus.out_bs  <= 1'b0;
      bus.out_rd  <= 1'b0;
    end else begin
      bus.out_rd <= 1'b0;
      if (state == IDLE) begin
        if (bus.in_send_en) begin
          shift_reg  <= bus.in_data;
`ifdef UART_TX_PARITY_EN
          parity_bit <= ^bus.in_data;
`endif
          baud_cnt   <= '0;
          bit_idx    <= '0;
          state      <= START;
          bus.out_tx <= 1'b0;
          bus.out_bs <= 1'b1;
        end
      end else if (!bit_end) begin
        baud_cnt <= baud_cnt + CNT_W'(1);
      end else begin
        // Bit boundary: the line value for the next bit period is loaded here.
        baud_cnt <= '0;
        unique case (state)
          START: begin
            state      <= DATA;
            bus.out_tx <= shift_reg[0];
            shift_reg  <= {1'b0, shift_reg[7:1]};
          end
          DATA: begin
            if (bit_idx == 3'd7) begin
              bit_idx    <= '0;
`ifdef UART_TX_PARITY_EN
              state      <= PARITY;
              bus.out_tx <= parity_bit;
`else
              state      <= STOP;
              bus.out_tx <= 1'b1;
`endif
            end else begin
              bit_idx    <= bit_idx + 3'd1;
              bus.out_tx <= shift_reg[0];
              shift_reg  <= {1'b0, shift_reg[7:1]};
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            state      <= STOP;
            bus.out_tx <= 1'b1;
          end
`endif
          STOP: begin
            // bit_idx is reused to count stop bits.
            if (bit_idx == STOP_LAST) begin
              bit_idx    <= '0;
              state      <= IDLE;
              bus.out_bs <= 1'b0;
              bus.out_rd <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
          default: begin
            state      <= IDLE;
            bus.out_tx <= 1'b1;
            bus.out_bs <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
